// File: rtl/fft_pkg.sv
// Shared constants, state encoding and twiddle-index rule for the 16-point FFT sequencer.
package fft_pkg;

  localparam int N_POINTS = 16;
  localparam int STAGES   = 4;
  localparam int N_BFU    = N_POINTS / 2;
  localparam int TW_IDX_W = 3;
  localparam int STAGE_W  = 2;
  localparam int BFU_W    = 3;

  localparam logic [STAGE_W-1:0] LAST_STAGE = 2'(STAGES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMPUTE,
    ST_HOLD
  } fft_seq_state_t;

  // k = (b >> (3 - s)) << (3 - s): clear the low (3 - s) bits of the butterfly index.
  function automatic logic [TW_IDX_W-1:0] tw_index(input logic [STAGE_W-1:0] s,
                                                   input logic [BFU_W-1:0] b);
    logic [STAGE_W-1:0] sh;
    sh = LAST_STAGE - s;
    return (b >> sh) << sh;
  endfunction

endpackage

// File: rtl/fft_twiddle_index.sv
// Combinational map from stage number to the packed per-butterfly twiddle indices.
module fft_twiddle_index
  import fft_pkg::*;
(
  input  logic [STAGE_W-1:0]        stage,
  output logic [N_BFU*TW_IDX_W-1:0] tw_idx
);

  for (genvar b = 0; b < N_BFU; b++) begin : g_bfu
    assign tw_idx[b*TW_IDX_W +: TW_IDX_W] = tw_index(stage, BFU_W'(b));
  end

endmodule

// File: rtl/fft_stage_sequencer.sv
// Control FSM for the 16-point radix-2 FFT: frame load, four butterfly stages, result hold.
// Optional compute stall input is enabled with the FFT_SEQ_STALL_EN macro.
module fft_stage_sequencer
  import fft_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
`ifdef FFT_SEQ_STALL_EN
  input  logic                        stall,
`endif
  input  logic                        frame_valid,
  output logic                        frame_ready,
  output logic                        load,
  output logic                        bfu_en,
  output logic [STAGE_W-1:0]          stage,
  output logic [N_BFU*TW_IDX_W-1:0]   tw_idx,
  output logic                        busy,
  output logic                        result_valid,
  output logic                        done,
  input  logic                        result_ack,
  output fft_seq_state_t              state_dbg
);

  // Handshakes: a frame transfers on an edge where frame_valid && frame_ready;
  // a spectrum is released on an edge where result_valid && result_ack.
  // Both ready/valid outputs are registered, so inputs never reach outputs combinationally.

  fft_seq_state_t              state;
  logic [STAGE_W-1:0]          cnt;
  logic [N_BFU*TW_IDX_W-1:0]   tw_next;
  logic                        stall_i;

`ifdef FFT_SEQ_STALL_EN
  assign stall_i = stall;
`else
  assign stall_i = 1'b0;
`endif

  assign state_dbg = state;

  // cnt is the stage to present on the next advancing COMPUTE cycle.
  fft_twiddle_index u_twiddle (
    .stage  (cnt),
    .tw_idx (tw_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      frame_ready  <= 1'b0;
      load         <= 1'b0;
      bfu_en       <= 1'b0;
      stage        <= '0;
      tw_idx       <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (frame_ready && frame_valid) begin
            state       <= ST_LOAD;
            frame_ready <= 1'b0;
            load        <= 1'b1;
            busy        <= 1'b1;
            cnt         <= '0;
          end else begin
            frame_ready <= 1'b1;
          end
        end
        ST_LOAD: begin
          state  <= ST_COMPUTE;
          load   <= 1'b0;
          bfu_en <= 1'b1;
          stage  <= cnt;
          tw_idx <= tw_next;
          cnt    <= cnt + 2'd1;
        end
        ST_COMPUTE: begin
          // A stall freezes stage/tw_idx; the shown stage has already been executed.
          if (stall_i) begin
            bfu_en <= 1'b0;
          end else if (stage == LAST_STAGE) begin
            state        <= ST_HOLD;
            bfu_en       <= 1'b0;
            stage        <= '0;
            tw_idx       <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b1;
            done         <= 1'b1;
          end else begin
            bfu_en <= 1'b1;
            stage  <= cnt;
            tw_idx <= tw_next;
            cnt    <= cnt + 2'd1;
          end
        end
        ST_HOLD: begin
          done <= 1'b0;
          if (result_ack) begin
            state        <= ST_IDLE;
            result_valid <= 1'b0;
            frame_ready  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/fft_stage_sequencer.md
# fft_stage_sequencer

Control FSM for the 16-point radix-2 FFT datapath. It accepts a frame of time-domain samples through a valid/ready handshake and pulses the datapath's sample-load strobe. It then steps the eight butterfly units through four stages, supplying the stage number and per-butterfly twiddle indices, and holds the result registers until the display side acknowledges them. It sits between the audio sample framer and the FFT processor and owns every control input of the butterfly array.

## Interface
- N_POINTS, 16: FFT length; fixed at 16 for this revision.
- STAGES, 4: log2(N_POINTS).
- N_BFU, 8: butterfly units, N_POINTS/2.
- TW_IDX_W, 3: width of one twiddle index k (selects W_16^k, k = 0..7).
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- frame_valid  in  1  framer has a complete 16-sample frame on t0..t15.
- frame_ready  out  1  sequencer can accept a frame.
- load  out  1  datapath captures t0..t15 into its working registers on this cycle's closing edge.
- bfu_en  out  1  datapath registers butterfly outputs on this cycle's closing edge.
- stage  out  2  current stage, 0..3; valid while bfu_en = 1.
- tw_idx  out  N_BFU*TW_IDX_W  twiddle index for butterfly b at bits [3b+2:3b].
- busy  out  1  a frame is loading or computing.
- result_valid  out  1  f0..f15 hold a finished spectrum.
- done  out  1  one-cycle pulse on the first cycle of result_valid.
- result_ack  in  1  consumer has taken the spectrum.
- stall  in  1  present only with FFT_SEQ_STALL_EN.

## Operation
- States: IDLE, LOAD, COMPUTE, HOLD.
- IDLE:
  - frame_ready = 1.
  - frame_valid high at an edge goes to LOAD.
- LOAD (1 cycle):
  - load = 1 and busy = 1.
  - Always goes to COMPUTE with the stage counter at 0.
- COMPUTE (4 cycles):
  - bfu_en = 1, busy = 1, stage = counter.
  - The counter increments each cycle.
  - After stage 3 the FSM goes to HOLD.
- HOLD:
  - result_valid = 1.
  - done = 1 on the first HOLD cycle only.
  - result_ack high at an edge goes to IDLE.
- Twiddle rule for stage s and butterfly b: k = (b >> (3 − s)) << (3 − s).
  - s=0: all 0.
  - s=1: 0,0,0,0,4,4,4,4.
  - s=2: 0,0,2,2,4,4,6,6.
  - s=3: 0..7.
- tw_idx = 0 outside COMPUTE.
- frame_ready = 0 in LOAD, COMPUTE and HOLD. frame_valid is ignored there; the framer must keep holding its frame.
- result_ack is ignored outside HOLD.
- In HOLD, if frame_valid and result_ack are both high, the FSM goes to IDLE only. The frame is accepted no earlier than the following edge.
- Reset (asynchronous, any state, including mid-COMPUTE):
  - The FSM returns to IDLE and the counter clears.
  - Any partial frame is abandoned; no done pulse is produced.

## Timing
- All outputs are registered, or decoded from registered state only; there are no input-to-output combinational paths.
- Reset values: frame_ready=0, load=0, bfu_en=0, stage=0, tw_idx=0, busy=0, result_valid=0, done=0.
- frame_ready rises on the first edge after rst_n deasserts.
- Handshake accepted at edge E0:
  - load is high in cycle E0–E1.
  - bfu_en is high from E1 to E5, covering stages 0,1,2,3.
  - result_valid and done rise at E5.
- Acceptance to result_valid: 5 cycles.
- With result_ack held high, a new frame can be accepted 2 edges after result_valid rises. Minimum frame period is 7 cycles.

## Configuration
- FFT_SEQ_STALL_EN defined:
  - Adds the stall input.
  - stall high in COMPUTE forces bfu_en = 0 and freezes the counter, stage and tw_idx.
  - Latency extends by the number of stalled COMPUTE cycles.
  - stall has no effect in IDLE, LOAD or HOLD.
- FFT_SEQ_STALL_EN undefined: no stall port, and the latency is fixed at 5.

## Structure
- Package fft_pkg holds:
  - N_POINTS, STAGES, N_BFU, TW_IDX_W;
  - the state enum fft_seq_state_t;
  - function tw_index(stage, b).
- Sub-module fft_twiddle_index is combinational: stage in, packed tw_idx out. The sequencer registers its output.
- Mapping k to W constants (Q1.15 re/im) stays in the datapath, not in this block.

## Test plan
- Reset release, then a single frame with result_ack high on the first HOLD cycle:
  - frame_ready rises on the first edge after reset.
  - load appears at cycle 1 after acceptance.
  - stage sequence is 0,1,2,3.
  - done appears 5 cycles after acceptance; the FSM is back in IDLE 1 edge later.
- tw_idx check: each COMPUTE cycle matches the rule, e.g. stage 2 gives {6,6,4,4,2,2,0,0} for b7..b0.
- frame_valid held high throughout, result_ack withheld for 10 cycles:
  - result_valid stays high and frame_ready stays 0.
  - No second load occurs until 2 edges after result_ack.
- rst_n pulsed low during stage 2:
  - All outputs go to zero immediately.
  - No done pulse; the next frame runs a full 5-cycle latency.
- frame_valid and result_ack both high in HOLD: the FSM goes to IDLE, and the frame is accepted at the next edge.
- FFT_SEQ_STALL_EN with stall high for 3 cycles during stage 1: stage holds at 1, bfu_en is low for those cycles, and done is seen 8 cycles after acceptance.
